nrf_rx_controller: RTL

Command sequencer that drives the nRF24L01 SPI datapath's control inputs and consumes its status outputs. It polls the radio's STATUS register and, when RX_DR is set, reads fixed-length payloads. After each payload it clears RX_DR and re-checks FIFO_STATUS, draining the RX FIFO before returning to polling. Payload bytes leave on a simple valid/last stream towards the packet consumer.

---
 rtl/nrf_rx_controller.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/nrf_rx_controller.sv
// Command sequencer for the nRF24L01 SPI datapath: polls STATUS, drains fixed-length RX payloads
// onto a valid/last byte stream, clearing RX_DR and re-checking FIFO_STATUS after each payload.
module nrf_rx_controller #(
  parameter int unsigned PAYLOAD_LEN = 32,
  parameter int unsigned POLL_CYCLES = 1000,
  parameter int unsigned CS_GAP      = 4,
  parameter int unsigned TIMEOUT     = 4096
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Enable,
  output logic [7:0]  o_Data,
  output logic        o_SPI_Csn,
  output logic        o_Load_TX,
  output logic        o_TX_DV,
  input  logic        i_TX_Ready,
  input  logic        i_RX_DV,
  output logic        o_Load_RX,
  input  logic [7:0]  i_RX_Data,
  input  logic        i_RX_DR_Set,
  input  logic        i_FIFO_Empty,
  output logic [7:0]  o_Payload_Byte,
  output logic        o_Payload_Valid,
  output logic        o_Payload_Last,
  output logic        o_Busy,
  output logic        o_Error,
  output logic [15:0] o_Pkt_Count
);

  typedef enum logic [3:0] {
    StIdle, StStart, StLoad, StSend, StWait, StLatch, StUse, StGap, StPollWait
  } state_e;

  typedef enum logic [1:0] {TxStatus, TxPayload, TxClear, TxFifo} txn_e;

  localparam logic [5:0] LastPayIdx = 6'(PAYLOAD_LEN);

  state_e      state_q, state_d;
  txn_e        txn_q, txn_d;
  logic [5:0]  idx_q, idx_d;
  logic [31:0] cnt_q, cnt_d;
  logic        poll_q, poll_d;
  logic [7:0]  data_q, data_d;
  logic [15:0] pkt_q, pkt_d;
  logic        err_q, err_d;

  // MOSI byte at position idx of each transaction; index 0 is the command byte.
  function automatic logic [7:0] tx_byte(input txn_e t, input logic [5:0] idx);
    logic first;
    first = (idx == 6'd0);
    unique case (t)
      TxStatus:  tx_byte = 8'hFF;
      TxPayload: tx_byte = first ? 8'h61 : 8'hFF;
      TxClear:   tx_byte = first ? 8'h27 : 8'h40;
      TxFifo:    tx_byte = first ? 8'h17 : 8'hFF;
    endcase
  endfunction

  function automatic logic [5:0] last_idx(input txn_e t);
    unique case (t)
      TxStatus:  last_idx = 6'd0;
      TxPayload: last_idx = LastPayIdx;
      TxClear:   last_idx = 6'd1;
      TxFifo:    last_idx = 6'd1;
    endcase
  endfunction

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= StIdle;
      txn_q   <= TxStatus;
      idx_q   <= 6'd0;
      cnt_q   <= 32'd0;
      poll_q  <= 1'b0;
      data_q  <= 8'h00;
      pkt_q   <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      txn_q   <= txn_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      poll_q  <= poll_d;
      data_q  <= data_d;
      pkt_q   <= pkt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    txn_d           = txn_q;
    idx_d           = idx_q;
    cnt_d           = cnt_q;
    poll_d          = poll_q;
    data_d          = data_q;
    pkt_d           = pkt_q;
    err_d           = 1'b0;
    o_Load_TX       = 1'b0;
    o_TX_DV         = 1'b0;
    o_Load_RX       = 1'b0;
    o_Payload_Valid = 1'b0;
    o_Payload_Last  = 1'b0;
    o_Payload_Byte  = 8'h00;

    case (state_q)
      StIdle: begin
        if (i_Enable) begin
          state_d = StStart;
          txn_d   = TxStatus;
          idx_d   = 6'd0;
        end
      end
      StStart: state_d = StLoad;
      StLoad: begin
        o_Load_TX = 1'b1;
        state_d   = StSend;
      end
      StSend: begin
        if (i_TX_Ready) begin
          o_TX_DV = 1'b1;
          cnt_d   = 32'd0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (i_RX_DV) begin
          state_d = StLatch;
        end else if (cnt_q == TIMEOUT - 1) begin
          // Abandon the chain; the payload (if any) is left without Last.
          err_d   = 1'b1;
          poll_d  = 1'b1;
          cnt_d   = 32'd0;
          idx_d   = 6'd0;
          state_d = StGap;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StLatch: begin
        o_Load_RX = 1'b1;
        state_d   = StUse;
      end
      StUse: begin
        if (txn_q == TxPayload && idx_q != 6'd0) begin
          o_Payload_Valid = 1'b1;
          o_Payload_Byte  = i_RX_Data;
          o_Payload_Last  = (idx_q == LastPayIdx);
        end
        if (idx_q != last_idx(txn_q)) begin
          idx_d   = idx_q + 6'd1;
          state_d = StLoad;
        end else begin
          idx_d   = 6'd0;
          cnt_d   = 32'd0;
          poll_d  = 1'b0;
          state_d = StGap;
          unique case (txn_q)
            TxStatus: begin
              if (i_RX_DR_Set) txn_d = TxPayload;
              else             poll_d = 1'b1;
            end
            TxPayload: begin
              txn_d = TxClear;
              pkt_d = pkt_q + 16'd1;
            end
            TxClear: txn_d = TxFifo;
            TxFifo: begin
              if (i_FIFO_Empty) poll_d = 1'b1;
              else              txn_d  = TxPayload;
            end
          endcase
        end
      end
      StGap: begin
        if (cnt_q >= CS_GAP - 1) begin
          cnt_d   = 32'd0;
          state_d = poll_q ? StPollWait : StStart;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StPollWait: begin
        if (cnt_q >= POLL_CYCLES - 1) begin
          cnt_d   = 32'd0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d == StLoad && state_q != StLoad) data_d = tx_byte(txn_d, idx_d);
  end

  assign o_SPI_Csn   = (state_q == StIdle) || (state_q == StGap) || (state_q == StPollWait);
  assign o_Busy      = !((state_q == StIdle) || (state_q == StPollWait));
  assign o_Data      = data_q;
  assign o_Error     = err_q;
  assign o_Pkt_Count = pkt_q;

endmodule
